vram_rect_fill_sequencer: RTL and testbench
===========================================

// Module: vram_rect_fill_sequencer
// PURPOSE
//  Hardware rectangle-fill engine and VRAM write-port arbiter between the CPU core and video memory.
//  Takes a rectangle command (x0,y0,x1,y1, inclusive bounds, plus colour) and emits one VRAM pixel write per cycle.
//  Write address = y*WIDTH + x, the same mapping the VGA instruction uses.
//  Shares the single VRAM write port with CPU VGA-instruction writes; the CPU always wins.
//  Replaces the software PINTAR_RECTANGULO loop for background and sprite fills.
// PARAMETERS
//  WIDTH   40  screen width in tiles; row stride
//  HEIGHT  30  screen height in tiles
//  AW      16  VRAM address width
//  CW      3   colour width
// PORTS
//  Clock       in   1   system clock, rising edge
//  Reset       in   1   asynchronous, active-high reset
//  iStart      in   1   command strobe; accepted only when oBusy=0
//  iX0,iY0     in   8   top-left corner
//  iX1,iY1     in   8   bottom-right corner, inclusive
//  iColor      in   CW  fill colour
//  iCpuWe      in   1   CPU VGA-instruction write request
//  iCpuAddr    in   AW  CPU write address
//  iCpuColor   in   CW  CPU write colour
//  oBusy       out  1   high from command accept until oDone
//  oDone       out  1   one-cycle completion pulse
//  oVramWe     out  1   VRAM write enable, registered
//  oVramAddr   out  AW  VRAM write address, registered
//  oVramColor  out  CW  VRAM write colour, registered
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; coordinate, row-base and colour registers 0.
//  FSM: IDLE -> LOAD -> FILL -> DONE -> IDLE.
//  - IDLE: on iStart, latch all command fields; next state LOAD; oBusy=1.
//  - LOAD: rowbase <= y0*WIDTH; x <= x0; y <= y0.
//    Next state is FILL, or DONE when x1<x0 or y1<y0 (empty command, zero writes).
//  - FILL: each cycle with iCpuWe=0, register a write of {rowbase+x, colour}.
//    Then if x<x1: x++. Otherwise x <= x0, y++, rowbase += WIDTH.
//    The write at (x1,y1) moves the FSM to DONE.
//  - DONE: oDone=1 and oBusy=0 for exactly this cycle; next state IDLE.
//  Arbitration: iCpuWe=1 in any state -> the next edge registers the CPU address/colour onto the VRAM port.
//    In FILL, the fill write is withheld and the x/y/rowbase counters hold (stall).
//    No write is ever lost or duplicated.
//  Latency: iStart sampled at edge E0. First fill write is visible after E2.
//    An N-pixel fill with no stalls has its last write visible after E(N+1) and oDone after E(N+2).
//    Each CPU stall cycle adds one cycle.
//  CPU write latency: 1 cycle, in every state.
//  Arithmetic: address is truncated to AW bits; rowbase is AW bits; x and y are 8 bits.
//  iStart while oBusy=1 is ignored, including during DONE; the command is not queued.
//  A new iStart is accepted in IDLE on the cycle after oDone.
//  Reset mid-fill aborts immediately: no oDone, no further writes.
//  oVramWe=0 on every cycle with neither a fill write nor a CPU write; address and colour hold their last value.
// CONFIGURATION
//  RECT_FILL_CLIP_EN defined:
//  - In LOAD, clamp x1 to WIDTH-1 and y1 to HEIGHT-1.
//  - If x0>=WIDTH or y0>=HEIGHT, go straight to DONE with zero writes.
//  RECT_FILL_CLIP_EN undefined:
//  - No clamping; out-of-range coordinates produce writes at the wrapped address, (y*WIDTH+x) mod 2^AW.
// TESTING
//  1. Reset, then (1,1)-(2,2) colour 5, WIDTH=40 -> writes 41,42,81,82, all colour 5.
//     Writes visible after E2..E5; oDone after E6; oBusy high E1..E5.
//  2. Fill (0,0)-(3,0); iCpuWe=1, addr 100, colour 2 on the cycle after the first fill write.
//     -> Sequence 0, 100, 1, 2, 3; oDone delayed by one cycle.
//  3. Fill (5,5)-(4,5) (x1<x0) -> zero writes; oDone after E2.
//     A second iStart during busy is ignored.
//  4. Assert Reset after the 3rd write of a (0,0)-(9,9) fill -> outputs 0 immediately, no oDone.
//     After release, iStart (0,0)-(0,0) -> single write to addr 0.
//  5. With RECT_FILL_CLIP_EN: (38,29)-(50,40) -> writes 1198 and 1199 only.
//     (45,0)-(46,0) -> zero writes, oDone.
//     Without the macro, the first command writes 156 pixels (13 x 12), starting at 1198.
//  6. CPU writes with the engine idle at addrs 7 then 8 on consecutive cycles.
//     -> oVramWe high for 2 cycles, one cycle later, with matching address and colour.

Source files
------------

// File: rtl/vram_rect_fill_sequencer.sv
// vram_rect_fill_sequencer
// Rectangle-fill engine that owns the single VRAM write port, with CPU
// VGA-instruction writes taking priority over fill writes.
// Optional feature macro: RECT_FILL_CLIP_EN (clamp/skip off-screen rectangles).
module vram_rect_fill_sequencer #(
    parameter int WIDTH  = 40,
    parameter int HEIGHT = 30,
    parameter int AW     = 16,
    parameter int CW     = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          iStart,
    input  logic [7:0]    iX0,
    input  logic [7:0]    iY0,
    input  logic [7:0]    iX1,
    input  logic [7:0]    iY1,
    input  logic [CW-1:0] iColor,
    input  logic          iCpuWe,
    input  logic [AW-1:0] iCpuAddr,
    input  logic [CW-1:0] iCpuColor,
    output logic          oBusy,
    output logic          oDone,
    output logic          oVramWe,
    output logic [AW-1:0] oVramAddr,
    output logic [CW-1:0] oVramColor
);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

    localparam logic [AW-1:0] STRIDE = AW'(WIDTH);

    state_t        state;
    state_t        state_n;
    logic [7:0]    x0_r;
    logic [7:0]    y0_r;
    logic [7:0]    x1_r;
    logic [7:0]    y1_r;
    logic [7:0]    x_r;
    logic [7:0]    y_r;
    logic [CW-1:0] col_r;
    logic [AW-1:0] rowbase;
    logic [7:0]    x1_eff;
    logic [7:0]    y1_eff;
    logic          oob;
    logic          empty;
    logic          fill_go;
    logic          last;

`ifdef RECT_FILL_CLIP_EN
    localparam logic [7:0] XMAX = 8'(WIDTH - 1);
    localparam logic [7:0] YMAX = 8'(HEIGHT - 1);

    // Clamp the far corner to the screen; an off-screen origin is an empty command
    always_comb begin
        x1_eff = (x1_r > XMAX) ? XMAX : x1_r;
        y1_eff = (y1_r > YMAX) ? YMAX : y1_r;
        oob    = (x0_r > XMAX) || (y0_r > YMAX);
    end
`else
    // Bounds used as given; out-of-range pixels wrap through the address arithmetic
    always_comb begin
        x1_eff = x1_r;
        y1_eff = y1_r;
        oob    = 1'b0;
    end
`endif

    // Fill-step qualifiers: CPU write stalls the fill; last pixel is the far corner
    always_comb begin
        fill_go = (state == FILL) && !iCpuWe;
        last    = (x_r == x1_r) && (y_r == y1_r);
        empty   = (x1_eff < x0_r) || (y1_eff < y0_r) || oob;
    end

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (iStart) state_n = LOAD;
            LOAD: state_n = empty ? DONE : FILL;
            FILL: if (fill_go && last) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Command latch, row-base setup and raster walk
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            x0_r    <= '0;
            y0_r    <= '0;
            x1_r    <= '0;
            y1_r    <= '0;
            x_r     <= '0;
            y_r     <= '0;
            col_r   <= '0;
            rowbase <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        x0_r  <= iX0;
                        y0_r  <= iY0;
                        x1_r  <= iX1;
                        y1_r  <= iY1;
                        col_r <= iColor;
                    end
                end
                LOAD: begin
                    rowbase <= AW'(y0_r) * STRIDE;
                    x_r     <= x0_r;
                    y_r     <= y0_r;
                    x1_r    <= x1_eff;
                    y1_r    <= y1_eff;
                end
                FILL: begin
                    if (fill_go) begin
                        if (x_r < x1_r) begin
                            x_r <= x_r + 8'd1;
                        end else begin
                            x_r     <= x0_r;
                            y_r     <= y_r + 8'd1;
                            rowbase <= rowbase + STRIDE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status and VRAM port; status lags the state by one cycle
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oVramWe    <= 1'b0;
            oVramAddr  <= '0;
            oVramColor <= '0;
        end else begin
            oBusy <= (state == LOAD) || (state == FILL);
            oDone <= (state == DONE);
            if (iCpuWe) begin
                oVramWe    <= 1'b1;
                oVramAddr  <= iCpuAddr;
                oVramColor <= iCpuColor;
            end else if (fill_go) begin
                oVramWe    <= 1'b1;
                oVramAddr  <= rowbase + AW'(x_r);
                oVramColor <= col_r;
            end else begin
                oVramWe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_rect_fill_sequencer.sv
// Directed testbench for vram_rect_fill_sequencer.
module tb_vram_rect_fill_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iStart = 1'b0;
    logic [7:0]  iX0 = '0;
    logic [7:0]  iY0 = '0;
    logic [7:0]  iX1 = '0;
    logic [7:0]  iY1 = '0;
    logic [2:0]  iColor = '0;
    logic        iCpuWe = 1'b0;
    logic [15:0] iCpuAddr = '0;
    logic [2:0]  iCpuColor = '0;
    logic        oBusy;
    logic        oDone;
    logic        oVramWe;
    logic [15:0] oVramAddr;
    logic [2:0]  oVramColor;

    int vectors = 0;
    int errors  = 0;

    vram_rect_fill_sequencer #(.WIDTH(40), .HEIGHT(30), .AW(16), .CW(3)) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart),
        .iX0(iX0), .iY0(iY0), .iX1(iX1), .iY1(iY1), .iColor(iColor),
        .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuColor(iCpuColor),
        .oBusy(oBusy), .oDone(oDone), .oVramWe(oVramWe),
        .oVramAddr(oVramAddr), .oVramColor(oVramColor)
    );

    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Present a command for one edge (E0)
    task automatic start_cmd(input logic [7:0] x0, input logic [7:0] y0,
                             input logic [7:0] x1, input logic [7:0] y1,
                             input logic [2:0] col);
        iX0 = x0; iY0 = y0; iX1 = x1; iY1 = y1; iColor = col;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if ({oBusy, oDone, oVramWe, oVramAddr, oVramColor} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {oBusy, oDone, oVramWe, oVramAddr, oVramColor});
        end
        tick();
        tick();
        Reset = 1'b0;
        tick();
        vectors++;
        if (oVramWe !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: we=%b busy=%b want 0 0", oVramWe, oBusy);
        end
    endtask

    task automatic test_basic_fill;
        logic [15:0] exp_a [4];
        exp_a[0] = 16'd41; exp_a[1] = 16'd42; exp_a[2] = 16'd81; exp_a[3] = 16'd82;
        start_cmd(8'd1, 8'd1, 8'd2, 8'd2, 3'd5);
        tick(); // E1
        vectors++;
        if (oBusy !== 1'b1 || oVramWe !== 1'b0) begin
            errors++;
            $display("FAIL basic_e1: busy=%b we=%b want 1 0", oBusy, oVramWe);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); // E2..E5
            vectors++;
            if (oVramWe !== 1'b1 || oVramAddr !== exp_a[i] || oVramColor !== 3'd5 || oBusy !== 1'b1) begin
                errors++;
                $display("FAIL basic_write%0d: we=%b addr=%0d col=%0d busy=%b want 1 %0d 5 1",
                         i, oVramWe, oVramAddr, oVramColor, oBusy, exp_a[i]);
            end
        end
        tick(); // E6
        vectors++;
        if (oDone !== 1'b1 || oBusy !== 1'b0 || oVramWe !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b we=%b want 1 0 0", oDone, oBusy, oVramWe);
        end
        tick();
        vectors++;
        if (oDone !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b want 0", oDone);
        end
    endtask

    task automatic test_cpu_stall;
        logic [15:0] exp_a [5];
        logic [2:0]  exp_c [5];
        exp_a[0] = 16'd0; exp_a[1] = 16'd100; exp_a[2] = 16'd1; exp_a[3] = 16'd2; exp_a[4] = 16'd3;
        exp_c[0] = 3'd1;  exp_c[1] = 3'd2;    exp_c[2] = 3'd1;  exp_c[3] = 3'd1;  exp_c[4] = 3'd1;
        start_cmd(8'd0, 8'd0, 8'd3, 8'd0, 3'd1);
        tick(); // E1
        for (int i = 0; i < 5; i++) begin
            tick(); // E2..E6
            iCpuWe = 1'b0;
            vectors++;
            if (oVramWe !== 1'b1 || oVramAddr !== exp_a[i] || oVramColor !== exp_c[i]) begin
                errors++;
                $display("FAIL stall_write%0d: we=%b addr=%0d col=%0d want 1 %0d %0d",
                         i, oVramWe, oVramAddr, oVramColor, exp_a[i], exp_c[i]);
            end
            if (i == 0) begin
                iCpuWe = 1'b1; iCpuAddr = 16'd100; iCpuColor = 3'd2;
            end
        end
        vectors++;
        if (oDone !== 1'b0) begin
            errors++;
            $display("FAIL stall_done_early: done=%b want 0", oDone);
        end
        tick(); // E7
        vectors++;
        if (oDone !== 1'b1 || oVramWe !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b we=%b want 1 0", oDone, oVramWe);
        end
        tick();
    endtask

    task automatic test_empty_and_ignore;
        start_cmd(8'd5, 8'd5, 8'd4, 8'd5, 3'd3);
        // second command while busy must be dropped
        iX0 = 8'd0; iY0 = 8'd0; iX1 = 8'd0; iY1 = 8'd0; iColor = 3'd7;
        iStart = 1'b1;
        tick(); // E1
        vectors++;
        if (oBusy !== 1'b1 || oVramWe !== 1'b0) begin
            errors++;
            $display("FAIL empty_e1: busy=%b we=%b want 1 0", oBusy, oVramWe);
        end
        tick(); // E2
        iStart = 1'b0;
        vectors++;
        if (oDone !== 1'b1 || oVramWe !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: done=%b we=%b busy=%b want 1 0 0", oDone, oVramWe, oBusy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (oVramWe !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
                errors++;
                $display("FAIL ignored_start%0d: we=%b busy=%b done=%b want 0 0 0", i, oVramWe, oBusy, oDone);
            end
        end
    endtask

    task automatic test_reset_abort;
        start_cmd(8'd0, 8'd0, 8'd9, 8'd9, 3'd6);
        tick(); // E1
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (oVramWe !== 1'b1 || oVramAddr !== 16'(i)) begin
                errors++;
                $display("FAIL abort_write%0d: we=%b addr=%0d want 1 %0d", i, oVramWe, oVramAddr, i);
            end
        end
        Reset = 1'b1;
        #1;
        vectors++;
        if ({oBusy, oDone, oVramWe, oVramAddr, oVramColor} !== 22'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %h want 0", {oBusy, oDone, oVramWe, oVramAddr, oVramColor});
        end
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (oVramWe !== 1'b0 || oDone !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: we=%b done=%b want 0 0", i, oVramWe, oDone);
            end
        end
        start_cmd(8'd0, 8'd0, 8'd0, 8'd0, 3'd4);
        tick(); // E1
        tick(); // E2
        vectors++;
        if (oVramWe !== 1'b1 || oVramAddr !== 16'd0 || oVramColor !== 3'd4) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%0d col=%0d want 1 0 4", oVramWe, oVramAddr, oVramColor);
        end
        tick(); // E3
        vectors++;
        if (oDone !== 1'b1 || oVramWe !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b we=%b want 1 0", oDone, oVramWe);
        end
        tick();
    endtask

    task automatic test_clip;
        int unsigned exp_q[$];
        int unsigned idx;
        logic        seen_done;
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            if (k == 0) begin
`ifdef RECT_FILL_CLIP_EN
                exp_q.push_back(1198);
                exp_q.push_back(1199);
`else
                for (int yy = 29; yy <= 40; yy++)
                    for (int xx = 38; xx <= 50; xx++)
                        exp_q.push_back(yy * 40 + xx);
`endif
                start_cmd(8'd38, 8'd29, 8'd50, 8'd40, 3'd7);
            end else begin
`ifndef RECT_FILL_CLIP_EN
                exp_q.push_back(45);
                exp_q.push_back(46);
`endif
                start_cmd(8'd45, 8'd0, 8'd46, 8'd0, 3'd2);
            end
            idx = 0;
            seen_done = 1'b0;
            for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
                tick();
                if (oVramWe === 1'b1) begin
                    vectors++;
                    if (idx >= exp_q.size()) begin
                        errors++;
                        $display("FAIL clip%0d_extra: addr=%0d beyond %0d expected writes", k, oVramAddr, exp_q.size());
                    end else if (oVramAddr !== 16'(exp_q[idx])) begin
                        errors++;
                        $display("FAIL clip%0d_addr%0d: got %0d want %0d", k, idx, oVramAddr, exp_q[idx]);
                    end
                    idx++;
                end
                if (oDone === 1'b1) seen_done = 1'b1;
            end
            vectors++;
            if (!seen_done || idx != exp_q.size()) begin
                errors++;
                $display("FAIL clip%0d_count: done=%b writes=%0d want 1 %0d", k, seen_done, idx, exp_q.size());
            end
            tick();
        end
    endtask

    task automatic test_cpu_idle;
        iCpuWe = 1'b1; iCpuAddr = 16'd7; iCpuColor = 3'd3;
        tick();
        vectors++;
        if (oVramWe !== 1'b1 || oVramAddr !== 16'd7 || oVramColor !== 3'd3) begin
            errors++;
            $display("FAIL cpu_w7: we=%b addr=%0d col=%0d want 1 7 3", oVramWe, oVramAddr, oVramColor);
        end
        iCpuAddr = 16'd8; iCpuColor = 3'd6;
        tick();
        iCpuWe = 1'b0;
        vectors++;
        if (oVramWe !== 1'b1 || oVramAddr !== 16'd8 || oVramColor !== 3'd6) begin
            errors++;
            $display("FAIL cpu_w8: we=%b addr=%0d col=%0d want 1 8 6", oVramWe, oVramAddr, oVramColor);
        end
        tick();
        vectors++;
        if (oVramWe !== 1'b0 || oVramAddr !== 16'd8 || oVramColor !== 3'd6 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL cpu_hold: we=%b addr=%0d col=%0d busy=%b want 0 8 6 0",
                     oVramWe, oVramAddr, oVramColor, oBusy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_cpu_stall();
        test_empty_and_ignore();
        test_reset_abort();
        test_clip();
        test_cpu_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
